integrator_chain: RTL

Cascaded N-stage two's-complement integrator with a valid pipeline, hold and clear. It is the inverse of the differentiator datapath. A stream of first differences from N cascaded `differentiator` stages is fed through an N-stage `integrator_chain` to reconstruct the original samples exactly, modulo 2^word_size, provided both ends start from reset. It sits on the receive/reconstruction side of the delta-coding path and doubles as the integrator section of a CIC decimator.

---
 rtl/integrator_pkg.sv | 36 +++
 rtl/integrator_chain_if.sv | 24 ++
 rtl/integrator_stage.sv | 56 +++++
 rtl/integrator_chain.sv | 48 ++++
 4 files changed

// File: rtl/integrator_pkg.sv
// Shared definitions for the delta-coding path: width/stage limits used by
// both the differentiator and integrator chains, plus per-stage helpers.
package integrator_pkg;

    localparam int INT_MAX_STAGES = 8;
    localparam int INT_WORD_SIZE  = 8;

    // Per-edge action of one stage, highest priority first.
    typedef enum logic [1:0] {
        STAGE_RESET,
        STAGE_CLEAR,
        STAGE_HOLD,
        STAGE_RUN
    } stage_op_e;

    function automatic stage_op_e decode_op(
        input logic reset,
        input logic clear,
        input logic hold
    );
        if (reset)      return STAGE_RESET;
        else if (clear) return STAGE_CLEAR;
        else if (hold)  return STAGE_HOLD;
        else            return STAGE_RUN;
    endfunction

    // Two's-complement add overflowed: same-sign operands, different-sign sum.
    function automatic logic signed_add_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/integrator_chain_if.sv
// Sample stream and control bundle between a producer and integrator_chain.
interface integrator_chain_if
    import integrator_pkg::*;
#(
    parameter int word_size = INT_WORD_SIZE
);
    logic [word_size-1:0] data_in;
    logic                 in_valid;
    logic                 hold;
    logic                 clear;
    logic [word_size-1:0] data_out;
    logic                 out_valid;
    logic                 overflow;

    modport master (
        output data_in, in_valid, hold, clear,
        input  data_out, out_valid, overflow
    );

    modport slave (
        input  data_in, in_valid, hold, clear,
        output data_out, out_valid, overflow
    );
endinterface

// File: rtl/integrator_stage.sv
// One integrator: wrapping accumulator, valid bit and sticky signed-overflow
// flag, with reset > clear > hold > run priority.
module integrator_stage
    import integrator_pkg::*;
#(
    parameter int word_size = INT_WORD_SIZE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 hold,
    input  logic [word_size-1:0] x,
    input  logic                 e,
    output logic [word_size-1:0] acc,
    output logic                 v,
    output logic                 ovf
);
    logic [word_size-1:0] r_acc;
    logic                 r_v;
    logic                 r_ovf;

    logic [word_size-1:0] w_sum;
    logic                 w_add_ovf;
    stage_op_e            w_op;

    assign w_sum     = r_acc + x;
    assign w_add_ovf = signed_add_ovf(r_acc[word_size-1], x[word_size-1], w_sum[word_size-1]);
    assign w_op      = decode_op(reset, clear, hold);

    // NOTE: non-blocking assignments so every stage samples its upstream
    // neighbour's pre-edge value; blocking here would collapse the cascade.
    always_ff @(posedge clock) begin
        case (w_op)
            STAGE_RESET, STAGE_CLEAR: begin
                r_acc <= '0;
                r_v   <= 1'b0;
                r_ovf <= 1'b0;
            end
            STAGE_HOLD: begin
            end
            default: begin
                if (e) begin
                    r_acc <= w_sum;
                    r_v   <= 1'b1;
                    if (w_add_ovf) r_ovf <= 1'b1;
                end else begin
                    r_v   <= 1'b0;
                end
            end
        endcase
    end

    assign acc = r_acc;
    assign v   = r_v;
    assign ovf = r_ovf;
endmodule

// File: rtl/integrator_chain.sv
// Cascade of `stages` integrators; reconstructs samples from an equal-depth
// differentiator chain (mod 2^word_size) and flags any signed overflow.
module integrator_chain
    import integrator_pkg::*;
#(
    parameter int word_size = INT_WORD_SIZE,
    parameter int stages    = 3
) (
    input  logic               clock,
    input  logic               reset,
    integrator_chain_if.slave  bus
);
    logic [word_size-1:0] w_acc [stages];
    logic [stages-1:0]    w_v;
    logic [stages-1:0]    w_ovf;

    for (genvar g = 0; g < stages; g++) begin : g_stage
        logic [word_size-1:0] w_x;
        logic                 w_e;

        // Stage 0 takes the input stream; later stages take the previous accumulator.
        if (g == 0) begin : g_head
            assign w_x = bus.data_in;
            assign w_e = bus.in_valid;
        end else begin : g_tail
            assign w_x = w_acc[g-1];
            assign w_e = w_v[g-1];
        end

        integrator_stage #(
            .word_size (word_size)
        ) u_stage (
            .clock (clock),
            .reset (reset),
            .clear (bus.clear),
            .hold  (bus.hold),
            .x     (w_x),
            .e     (w_e),
            .acc   (w_acc[g]),
            .v     (w_v[g]),
            .ovf   (w_ovf[g])
        );
    end

    assign bus.data_out  = w_acc[stages-1];
    assign bus.out_valid = w_v[stages-1];
    assign bus.overflow  = |w_ovf;
endmodule
